// File: rtl/add8_serial_if.sv
// Operand/result handshake bundle for the bit-serial adder.
// The master drives operands and accepts results; the slave is the adder itself.
interface add8_serial_if #(
    parameter int WIDTH = 8
);
    logic             in_valid;
    logic             in_ready;
    logic [WIDTH-1:0] a;
    logic [WIDTH-1:0] b;
    logic             cin;
    logic             out_valid;
    logic             out_ready;
    logic [WIDTH-1:0] sum;
    logic             cout;
    logic             ovf;

    modport master (
        output in_valid, a, b, cin, out_ready,
        input  in_ready, out_valid, sum, cout, ovf
    );

    modport slave (
        input  in_valid, a, b, cin, out_ready,
        output in_ready, out_valid, sum, cout, ovf
    );
endinterface

// File: rtl/add8_serial.sv
// Bit-serial adder with carry-in: one full-adder cell, LSB first, one bit per clock.
// Produces sum, carry-out and signed overflow behind a valid/ready result handshake.
module add8_serial #(
    parameter int WIDTH = 8,
    parameter int CW    = 6
) (
    input logic          clk,
    input logic          rst_n,
    add8_serial_if.slave bus
);
    typedef enum logic [1:0] {
        IDLE,
        RUN,
        DONE
    } state_t;

    localparam logic [CW-1:0] LAST = CW'(WIDTH - 1);

    state_t           state;
    logic [CW-1:0]    cnt;
    logic [WIDTH-1:0] a_q;
    logic [WIDTH-1:0] b_q;
    logic [WIDTH-1:0] sum_q;
    logic             c_q;
    logic             cout_q;
    logic             ovf_q;
    logic             in_ready_q;
    logic             out_valid_q;
    logic             s_bit;
    logic             c_next;

    // The operand registers shift right every bit cycle, so the cell always sees bit 0.
    always_comb begin
        s_bit  = a_q[0] ^ b_q[0] ^ c_q;
        c_next = (a_q[0] & b_q[0]) | (a_q[0] & c_q) | (b_q[0] & c_q);
    end

    // NOTE: all state below updates with non-blocking assignments so every register
    // samples the pre-edge values of the others, matching real flop behaviour.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state       <= IDLE;
            cnt         <= '0;
            a_q         <= '0;
            b_q         <= '0;
            c_q         <= 1'b0;
            sum_q       <= '0;
            cout_q      <= 1'b0;
            ovf_q       <= 1'b0;
            in_ready_q  <= 1'b0;
            out_valid_q <= 1'b0;
        end else begin
            case (state)
                IDLE: begin
                    in_ready_q <= 1'b1;
                    // in_ready_q gates acceptance so the first edge after reset only raises ready.
                    if (in_ready_q && bus.in_valid) begin
                        a_q        <= bus.a;
                        b_q        <= bus.b;
                        c_q        <= bus.cin;
                        cnt        <= '0;
                        in_ready_q <= 1'b0;
                        state      <= RUN;
                    end
                end
                RUN: begin
                    a_q   <= a_q >> 1;
                    b_q   <= b_q >> 1;
                    c_q   <= c_next;
                    sum_q <= {s_bit, sum_q[WIDTH-1:1]};
                    cnt   <= cnt + 1'b1;
                    if (cnt == LAST) begin
                        cout_q      <= c_next;
                        // c_q here is the carry into the MSB.
                        ovf_q       <= c_q ^ c_next;
                        out_valid_q <= 1'b1;
                        state       <= DONE;
                    end
                end
                DONE: begin
                    if (bus.out_ready) begin
                        out_valid_q <= 1'b0;
                        in_ready_q  <= 1'b1;
                        state       <= IDLE;
                    end
                end
                default: begin
                    state       <= IDLE;
                    in_ready_q  <= 1'b0;
                    out_valid_q <= 1'b0;
                end
            endcase
        end
    end

    assign bus.in_ready  = in_ready_q;
    assign bus.out_valid = out_valid_q;
    assign bus.sum       = sum_q;
    assign bus.cout      = cout_q;
    assign bus.ovf       = ovf_q;
endmodule

// File: tb/tb_add8_serial.sv
// Self-checking bench for add8_serial: directed corner cases plus random operands
// compared against an arithmetic reference model.
module tb_add8_serial;
    localparam int W = 8;

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    int   tests = 0;
    int   fails = 0;

    add8_serial_if #(.WIDTH(W)) bus ();

    add8_serial #(.WIDTH(W), .CW(6)) dut (
        .clk  (clk),
        .rst_n(rst_n),
        .bus  (bus)
    );

    always #5 clk = ~clk;

    // Reference: {ovf, cout, sum} from plain integer addition.
    function automatic logic [W+1:0] model(input logic [W-1:0] a, input logic [W-1:0] b,
                                          input logic cin);
        logic [W:0] t;
        logic       v;
        t = {1'b0, a} + {1'b0, b} + {{W{1'b0}}, cin};
        v = (a[W-1] == b[W-1]) && (t[W-1] != a[W-1]);
        return {v, t};
    endfunction

    // Runs one operation; lat is edges from acceptance to out_valid, -1 on timeout.
    task automatic do_op(input logic [W-1:0] a, input logic [W-1:0] b, input logic cin,
                         output logic [W-1:0] s, output logic co, output logic ov,
                         output int lat, output logic ready_after_e0);
        int n;
        n = 0;
        while (!bus.in_ready && n < 50) begin
            @(posedge clk);
            @(negedge clk);
            n++;
        end
        bus.a = a;
        bus.b = b;
        bus.cin = cin;
        bus.in_valid = 1'b1;
        @(posedge clk);
        @(negedge clk);
        bus.in_valid = 1'b0;
        bus.a = $urandom;
        bus.b = $urandom;
        bus.cin = $urandom;
        ready_after_e0 = bus.in_ready;
        lat = 0;
        while (!bus.out_valid && lat < 40) begin
            @(posedge clk);
            lat++;
            @(negedge clk);
        end
        if (!bus.out_valid) lat = -1;
        s  = bus.sum;
        co = bus.cout;
        ov = bus.ovf;
        bus.out_ready = 1'b1;
        @(posedge clk);
        @(negedge clk);
        bus.out_ready = 1'b0;
    endtask

    task automatic test_reset();
        repeat (3) @(posedge clk);
        @(negedge clk);
        tests++;
        if (bus.in_ready !== 1'b0 || bus.out_valid !== 1'b0 || bus.sum !== '0 ||
            bus.cout !== 1'b0 || bus.ovf !== 1'b0) begin
            fails++;
            $display("FAIL reset_state: rdy=%b vld=%b sum=%h cout=%b ovf=%b, want 0 0 00 0 0",
                     bus.in_ready, bus.out_valid, bus.sum, bus.cout, bus.ovf);
        end
        rst_n = 1'b1;
        #1;
        tests++;
        if (bus.in_ready !== 1'b0) begin
            fails++;
            $display("FAIL ready_before_edge: got %b want 0", bus.in_ready);
        end
        @(negedge clk);
        tests++;
        if (bus.in_ready !== 1'b1) begin
            fails++;
            $display("FAIL ready_after_edge: got %b want 1", bus.in_ready);
        end
    endtask

    task automatic test_basic();
        logic [W-1:0] s;
        logic co, ov, rdy;
        int lat;
        do_op(8'h0F, 8'h01, 1'b0, s, co, ov, lat, rdy);
        tests++;
        if (rdy !== 1'b0) begin
            fails++;
            $display("FAIL basic_ready_drop: got %b want 0", rdy);
        end
        tests++;
        if (lat != W) begin
            fails++;
            $display("FAIL basic_latency: got %0d want %0d", lat, W);
        end
        tests++;
        if ({s, co, ov} !== {8'h10, 1'b0, 1'b0}) begin
            fails++;
            $display("FAIL basic_result: got sum=%h cout=%b ovf=%b want 10 0 0", s, co, ov);
        end
    endtask

    task automatic test_flags();
        logic [W-1:0] va [5] = '{8'hFF, 8'h7F, 8'h80, 8'hFF, 8'h00};
        logic [W-1:0] vb [5] = '{8'h01, 8'h01, 8'h80, 8'hFF, 8'h00};
        logic         vc [5] = '{1'b0, 1'b0, 1'b0, 1'b1, 1'b1};
        logic [W+1:0] want [5] = '{{1'b0, 1'b1, 8'h00}, {1'b1, 1'b0, 8'h80},
                                   {1'b1, 1'b1, 8'h00}, {1'b0, 1'b1, 8'hFF},
                                   {1'b0, 1'b0, 8'h01}};
        logic [W-1:0] s;
        logic co, ov, rdy;
        int lat;
        for (int i = 0; i < 5; i++) begin
            do_op(va[i], vb[i], vc[i], s, co, ov, lat, rdy);
            tests++;
            if ({ov, co, s} !== want[i] || lat != W) begin
                fails++;
                $display("FAIL flags_%0d: %h+%h+%b got ovf=%b cout=%b sum=%h lat=%0d want %b %b %h lat=%0d",
                         i, va[i], vb[i], vc[i], ov, co, s, lat, want[i][W+1], want[i][W],
                         want[i][W-1:0], W);
            end
        end
    endtask

    task automatic test_random();
        logic [W-1:0] a, b, s;
        logic c, co, ov, rdy;
        logic [W+1:0] want;
        int lat;
        for (int i = 0; i < 20; i++) begin
            a = $urandom;
            b = $urandom;
            c = $urandom;
            if (i == 0) begin
                a = '0;
                b = '0;
                c = 1'b0;
            end
            want = model(a, b, c);
            do_op(a, b, c, s, co, ov, lat, rdy);
            tests++;
            if ({ov, co, s} !== want || lat != W) begin
                fails++;
                $display("FAIL random_%0d: %h+%h+%b got {ovf,cout,sum}=%h lat=%0d want %h lat=%0d",
                         i, a, b, c, {ov, co, s}, lat, want, W);
            end
        end
    endtask

    task automatic test_backpressure();
        logic [W-1:0] s0, s;
        logic c0, v0, co, ov, rdy;
        int n;
        bus.a = 8'h3C;
        bus.b = 8'h55;
        bus.cin = 1'b1;
        bus.in_valid = 1'b1;
        @(posedge clk);
        @(negedge clk);
        bus.in_valid = 1'b0;
        n = 0;
        while (!bus.out_valid && n < 40) begin
            @(posedge clk);
            @(negedge clk);
            n++;
        end
        s0 = bus.sum;
        c0 = bus.cout;
        v0 = bus.ovf;
        tests++;
        if ({v0, c0, s0} !== model(8'h3C, 8'h55, 1'b1) || !bus.out_valid) begin
            fails++;
            $display("FAIL bp_result: vld=%b got %h want %h", bus.out_valid, {v0, c0, s0},
                     model(8'h3C, 8'h55, 1'b1));
        end
        for (int i = 0; i < 5; i++) begin
            bus.in_valid = ~bus.in_valid;
            bus.a = $urandom;
            bus.b = $urandom;
            bus.cin = $urandom;
            @(posedge clk);
            @(negedge clk);
            tests++;
            if (bus.out_valid !== 1'b1 || bus.in_ready !== 1'b0 ||
                {bus.ovf, bus.cout, bus.sum} !== {v0, c0, s0}) begin
                fails++;
                $display("FAIL bp_hold_%0d: vld=%b rdy=%b res=%h want 1 0 %h", i, bus.out_valid,
                         bus.in_ready, {bus.ovf, bus.cout, bus.sum}, {v0, c0, s0});
            end
        end
        bus.in_valid = 1'b0;
        bus.out_ready = 1'b1;
        @(posedge clk);
        @(negedge clk);
        bus.out_ready = 1'b0;
        tests++;
        if (bus.in_ready !== 1'b1 || bus.out_valid !== 1'b0) begin
            fails++;
            $display("FAIL bp_release: rdy=%b vld=%b want 1 0", bus.in_ready, bus.out_valid);
        end
        do_op(8'h21, 8'h43, 1'b0, s, co, ov, n, rdy);
        tests++;
        if ({ov, co, s} !== model(8'h21, 8'h43, 1'b0)) begin
            fails++;
            $display("FAIL bp_next_op: got %h want %h", {ov, co, s}, model(8'h21, 8'h43, 1'b0));
        end
    endtask

    task automatic test_back_to_back();
        logic [W-1:0] pa [2] = '{8'h12, 8'hA5};
        logic [W-1:0] pb [2] = '{8'h34, 8'h5A};
        logic [W-1:0] res [2];
        int e0 [2];
        int nacc, nres, cyc;
        logic pending;
        nacc = 0;
        nres = 0;
        pending = 1'b0;
        res[0] = 'x;
        res[1] = 'x;
        e0[0] = 0;
        e0[1] = 0;
        bus.a = pa[0];
        bus.b = pb[0];
        bus.cin = 1'b0;
        bus.in_valid = 1'b1;
        bus.out_ready = 1'b1;
        for (cyc = 0; cyc < 60 && nres < 2; cyc++) begin
            if (pending) begin
                bus.a = (nacc < 2) ? pa[nacc] : W'($urandom);
                bus.b = (nacc < 2) ? pb[nacc] : W'($urandom);
                pending = 1'b0;
            end
            if (bus.out_valid) begin
                res[nres] = bus.sum;
                nres++;
            end
            if (bus.in_ready && nacc < 2) begin
                e0[nacc] = cyc;
                nacc++;
                pending = 1'b1;
            end
            if (nres == 2) bus.in_valid = 1'b0;
            @(posedge clk);
            @(negedge clk);
        end
        bus.in_valid = 1'b0;
        bus.out_ready = 1'b0;
        @(posedge clk);
        @(negedge clk);
        tests++;
        if (nres != 2 || res[0] !== 8'h46 || res[1] !== 8'hFF) begin
            fails++;
            $display("FAIL b2b_results: got n=%0d %h %h want 2 46 ff", nres, res[0], res[1]);
        end
        tests++;
        if (nacc != 2 || e0[1] - e0[0] != W + 2) begin
            fails++;
            $display("FAIL b2b_spacing: got %0d want %0d", e0[1] - e0[0], W + 2);
        end
    endtask

    task automatic test_reset_mid_run();
        logic [W-1:0] s;
        logic co, ov, rdy, saw_valid;
        int lat;
        bus.a = 8'hF0;
        bus.b = 8'h0F;
        bus.cin = 1'b0;
        bus.in_valid = 1'b1;
        bus.out_ready = 1'b1;
        @(posedge clk);
        @(negedge clk);
        bus.in_valid = 1'b0;
        repeat (4) @(posedge clk);
        #2;
        rst_n = 1'b0;
        #1;
        tests++;
        if (bus.out_valid !== 1'b0 || bus.in_ready !== 1'b0 || bus.sum !== '0 ||
            bus.cout !== 1'b0 || bus.ovf !== 1'b0) begin
            fails++;
            $display("FAIL midrun_clear: vld=%b rdy=%b sum=%h cout=%b ovf=%b want all 0",
                     bus.out_valid, bus.in_ready, bus.sum, bus.cout, bus.ovf);
        end
        saw_valid = 1'b0;
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            saw_valid |= bus.out_valid;
        end
        rst_n = 1'b1;
        for (int i = 0; i < W + 2; i++) begin
            @(negedge clk);
            saw_valid |= bus.out_valid;
        end
        bus.out_ready = 1'b0;
        tests++;
        if (saw_valid !== 1'b0 || bus.in_ready !== 1'b1) begin
            fails++;
            $display("FAIL midrun_no_pulse: saw_valid=%b rdy=%b want 0 1", saw_valid, bus.in_ready);
        end
        do_op(8'h01, 8'h01, 1'b0, s, co, ov, lat, rdy);
        tests++;
        if ({ov, co, s} !== {1'b0, 1'b0, 8'h02} || lat != W) begin
            fails++;
            $display("FAIL midrun_recover: got ovf=%b cout=%b sum=%h lat=%0d want 0 0 02 %0d",
                     ov, co, s, lat, W);
        end
    endtask

    initial begin
        bus.in_valid = 1'b0;
        bus.out_ready = 1'b0;
        bus.a = '0;
        bus.b = '0;
        bus.cin = 1'b0;
        test_reset();
        test_basic();
        test_flags();
        test_random();
        test_backpressure();
        test_back_to_back();
        test_reset_mid_run();
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end
endmodule
